// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional feature macro: UART_ARB_HDR_EN (adds a one-byte source header per packet).
package uart_arb_pkg;

   // Arbiter FSM states; ST_HDR is only reachable when UART_ARB_HDR_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HDR   = 2'd1,
      ST_XFER  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_t;

   // Upper nibble of the per-packet header byte; the lower nibble is the source index.
   localparam logic [3:0] HDR_TAG = 4'hA;

   // Width of a requester index; never below one bit so N_REQ=2 still gets a usable field.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin priority encoder: scans the request vector
// upward from ptr, wrapping at N_REQ-1, and reports the first active entry.
// Optional feature macro of the enclosing design: UART_ARB_HDR_EN (not used here).
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Walk every offset from ptr; the first hit wins and later hits are ignored.
   always_comb begin
      int   pos;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int off = 0; off < N_REQ; off++) begin
         pos = (int'(ptr) + off) % N_REQ;
         if (!found && req[IDX_W'(pos)]) begin
            found = 1'b1;
            grant = N_REQ'(1) << pos;
            idx   = IDX_W'(pos);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among
// N_REQ byte-stream requesters. A granted requester owns the transmitter
// until its LAST byte has been taken by the UART, so packets never interleave.
// Optional feature macro: UART_ARB_HDR_EN -- when defined, each packet is
// preceded by a header byte {4'hA, source index}.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                 SCLK,
   input  logic                 RESET_N,
   input  logic [N_REQ-1:0]     REQ_VALID,
   input  logic [8*N_REQ-1:0]   REQ_DATA,
   input  logic [N_REQ-1:0]     REQ_LAST,
   output logic [N_REQ-1:0]     REQ_READY,
   output logic                 TX_VALID,
   output logic [7:0]           TX_DATA,
   input  logic                 TX_READY,
   output logic [N_REQ-1:0]     GRANT,
   output logic                 BUSY
);

   localparam int IDX_W = idx_width(N_REQ);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q, tx_data_d;

   logic [N_REQ-1:0] pick_grant;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   logic             tx_fire;
   logic             out_free;
   logic             cur_valid;
   logic             cur_last;
   logic [7:0]       cur_data;
   logic [IDX_W-1:0] next_ptr;

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (REQ_VALID),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // The output register can take a new byte when empty or when the UART is draining it this cycle.
   assign tx_fire  = tx_valid_q & TX_READY;
   assign out_free = ~tx_valid_q | tx_fire;
   assign next_ptr = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

   // One-hot mux of the owner's valid/last/data, driven by the registered grant.
   always_comb begin
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            cur_valid = REQ_VALID[i];
            cur_last  = REQ_LAST[i];
            cur_data  = REQ_DATA[8*i +: 8];
         end
      end
   end

   // Next-state, grant bookkeeping, output-register loading and requester ready.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      rr_ptr_d   = rr_ptr_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      REQ_READY  = '0;

      if (tx_fire) begin
         tx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_grant;
               idx_d   = pick_idx;
`ifdef UART_ARB_HDR_EN
               state_d = ST_HDR;
`else
               state_d = ST_XFER;
`endif
            end
         end
`ifdef UART_ARB_HDR_EN
         ST_HDR: begin
            // The output register is always empty on entry, so the header loads on the first HDR cycle;
            // afterwards wait for the UART to take it before opening the owner's stream.
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = {HDR_TAG, 4'(idx_q)};
            end else if (tx_fire) begin
               state_d = ST_XFER;
            end
         end
`endif
         ST_XFER: begin
            REQ_READY = grant_q & {N_REQ{out_free}};
            if (cur_valid && out_free) begin
               tx_valid_d = 1'b1;
               tx_data_d  = cur_data;
               if (cur_last) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (tx_fire) begin
               grant_d  = '0;
               rr_ptr_d = next_ptr;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any packet in flight.
   always_ff @(posedge SCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         idx_q      <= '0;
         rr_ptr_q   <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idx_q      <= idx_d;
         rr_ptr_q   <= rr_ptr_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign TX_VALID = tx_valid_q;
   assign TX_DATA  = tx_data_q;
   assign GRANT    = grant_q;
   assign BUSY     = (state_q != ST_IDLE);

endmodule
